// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: machine width, default reset vector,
// PC sequencer state encoding and a small alignment helper.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0100_0000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        HALT  = ST_HALT,
        ERROR = ST_ERROR
    } seq_state_t;

    // An RV32I instruction address must have its two low bits clear.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master)
// and instruction memory (slave).
interface pc_sequencer_if;
    import rv32_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );

endinterface

// File: rtl/pc_sequencer_inc.sv
// Combinational PC incrementer: next sequential address, wrapping
// modulo 2^WIDTH so the top word rolls over to zero.
module pc_sequencer_inc
    import rv32_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4
);

    assign pc_plus4 = pc + WIDTH'(4);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the fetch handshake with
// instruction memory and picks the next PC from sequential, redirect or hold.
// RESET_VECTOR is expected to be word-aligned.
module pc_sequencer #(
    parameter int                XLEN         = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_VECTOR = rv32_pkg::DEFAULT_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              halt_req,
    pc_sequencer_if.master    imem,
    output logic              inst_valid,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              misalign_err,
    output logic              halted
);
    import rv32_pkg::*;

    seq_state_t      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic            req;

    pc_sequencer_inc #(
        .WIDTH (XLEN)
    ) u_inc (
        .pc       (pc),
        .pc_plus4 (pc_next_seq)
    );

    assign pc_out         = pc;
    assign pc_plus4       = pc_next_seq;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = req;

    // Sequencer FSM: all status outputs are registered alongside the state
    // so they change exactly on the edge that enters each state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_VECTOR;
            req          <= 1'b0;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
            halted       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end

                FETCH: begin
                    if (imem.imem_ack) begin
                        state      <= ISSUE;
                        req        <= 1'b0;
                        inst_valid <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (redirect_valid) begin
                        if (is_word_aligned(redirect_target)) begin
                            pc         <= redirect_target;
                            state      <= FETCH;
                            req        <= 1'b1;
                            inst_valid <= 1'b0;
                        end else begin
                            state        <= ERROR;
                            inst_valid   <= 1'b0;
                            misalign_err <= 1'b1;
                            halted       <= 1'b1;
                        end
                    end else if (halt_req) begin
                        state      <= HALT;
                        inst_valid <= 1'b0;
                        halted     <= 1'b1;
                    end else if (!stall) begin
                        pc         <= pc_next_seq;
                        state      <= FETCH;
                        req        <= 1'b1;
                        inst_valid <= 1'b0;
                    end
                end

                HALT: begin
                    req        <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                end

                ERROR: begin
                    req          <= 1'b0;
                    inst_valid   <= 1'b0;
                    misalign_err <= 1'b1;
                    halted       <= 1'b1;
                end

                default: begin
                    state      <= IDLE;
                    req        <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: walks the fetch/issue loop, redirect
// priority, stall hold, misaligned redirect, PC wrap, halt and mid-fetch reset.
module tb_pc_sequencer;

    localparam logic [31:0] RV      = 32'h0100_0000;
    localparam logic [31:0] RV_WRAP = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        ack;

    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic        halted;

    logic        w_inst_valid;
    logic [31:0] w_pc_out;
    logic [31:0] w_pc_plus4;
    logic        w_misalign_err;
    logic        w_halted;

    int assert_count;
    int fail_count;

    pc_sequencer_if bus ();
    pc_sequencer_if wrap_bus ();

    assign bus.imem_ack      = ack;
    assign wrap_bus.imem_ack = ack;

    pc_sequencer #(
        .RESET_VECTOR (RV)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem            (bus.master),
        .inst_valid      (inst_valid),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .misalign_err    (misalign_err),
        .halted          (halted)
    );

    pc_sequencer #(
        .RESET_VECTOR (RV_WRAP)
    ) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .imem            (wrap_bus.master),
        .inst_valid      (w_inst_valid),
        .pc_out          (w_pc_out),
        .pc_plus4        (w_pc_plus4),
        .misalign_err    (w_misalign_err),
        .halted          (w_halted)
    );

    // Free-running 100 MHz-style clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] tgt,
                                 input logic hr, input logic ak);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        halt_req        = hr;
        ack             = ak;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_pc"}, pc_out, RV);
        checkOutput({tag, "_pc4"}, pc_plus4, RV + 32'd4);
        checkOutput({tag, "_addr"}, bus.imem_addr, RV);
        checkOutput({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
        checkOutput({tag, "_ival"}, {31'd0, inst_valid}, 32'd0);
        checkOutput({tag, "_mis"}, {31'd0, misalign_err}, 32'd0);
        checkOutput({tag, "_halt"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        assert_count    = 0;
        fail_count      = 0;
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        halt_req        = 1'b0;
        ack             = 1'b0;

        tick(2);
        checkReset("reset");

        // Sequential fetch with ack tied high.
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            checkOutput($sformatf("seq%0d_req", k), {31'd0, bus.imem_req}, 32'd1);
            checkOutput($sformatf("seq%0d_addr", k), bus.imem_addr, RV + 32'(4 * k));
            checkOutput($sformatf("seq%0d_ival_lo", k), {31'd0, inst_valid}, 32'd0);
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            checkOutput($sformatf("seq%0d_ival", k), {31'd0, inst_valid}, 32'd1);
            checkOutput($sformatf("seq%0d_pc", k), pc_out, RV + 32'(4 * k));
            checkOutput($sformatf("seq%0d_req_lo", k), {31'd0, bus.imem_req}, 32'd0);
        end
        tick(4);
        checkOutput("at10_pc", pc_out, 32'h0100_0010);
        checkOutput("at10_ival", {31'd0, inst_valid}, 32'd1);

        // Redirect from ISSUE skips the sequential address.
        applyStimulus(1'b0, 1'b1, 32'h0100_0100, 1'b0, 1'b1);
        checkOutput("redir_addr", bus.imem_addr, 32'h0100_0100);
        checkOutput("redir_req", {31'd0, bus.imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("redir_issue_pc", pc_out, 32'h0100_0100);

        // Redirect beats halt and stall.
        applyStimulus(1'b1, 1'b1, 32'h0100_0200, 1'b1, 1'b1);
        checkOutput("prio_addr", bus.imem_addr, 32'h0100_0200);
        checkOutput("prio_req", {31'd0, bus.imem_req}, 32'd1);
        checkOutput("prio_halt", {31'd0, halted}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("prio_issue_pc", pc_out, 32'h0100_0200);

        // Stall holds ISSUE for three cycles.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
            checkOutput($sformatf("stall%0d_pc", k), pc_out, 32'h0100_0200);
            checkOutput($sformatf("stall%0d_ival", k), {31'd0, inst_valid}, 32'd1);
            checkOutput($sformatf("stall%0d_req", k), {31'd0, bus.imem_req}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("unstall_addr", bus.imem_addr, 32'h0100_0204);
        checkOutput("unstall_req", {31'd0, bus.imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Misaligned redirect enters the sticky error state.
        applyStimulus(1'b0, 1'b1, 32'h0100_0102, 1'b0, 1'b1);
        checkOutput("mis_err", {31'd0, misalign_err}, 32'd1);
        checkOutput("mis_halt", {31'd0, halted}, 32'd1);
        checkOutput("mis_pc", pc_out, 32'h0100_0204);
        checkOutput("mis_ival", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
            checkOutput($sformatf("mis_hold%0d_req", k), {31'd0, bus.imem_req}, 32'd0);
            checkOutput($sformatf("mis_hold%0d_err", k), {31'd0, misalign_err}, 32'd1);
        end

        // PC wrap from the top word, on the wrap instance.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkReset("rst2");
        checkOutput("wrap_rst_pc", w_pc_out, RV_WRAP);
        checkOutput("wrap_rst_pc4", w_pc_plus4, 32'h0000_0000);
        rst_n = 1'b1;
        tick(3);
        checkOutput("wrap_addr", wrap_bus.imem_addr, 32'h0000_0000);
        checkOutput("wrap_req", {31'd0, wrap_bus.imem_req}, 32'd1);
        checkOutput("wrap_mis", {31'd0, w_misalign_err}, 32'd0);
        checkOutput("wrap_halt", {31'd0, w_halted}, 32'd0);

        // Main instance now in FETCH at RV+4; take it to ISSUE then halt.
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("pre_halt_pc", pc_out, RV + 32'd4);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        checkOutput("halt_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_ival", {31'd0, inst_valid}, 32'd0);
        checkOutput("halt_req_lo", {31'd0, bus.imem_req}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, k[0]);
            checkOutput($sformatf("halt_ack%0d_req", k), {31'd0, bus.imem_req}, 32'd0);
            checkOutput($sformatf("halt_ack%0d_ival", k), {31'd0, inst_valid}, 32'd0);
            checkOutput($sformatf("halt_ack%0d_pc", k), pc_out, RV + 32'd4);
        end

        // Reset in the middle of a fetch aborts it.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkReset("rst3");
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("mid_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        checkOutput("mid_fetch_wait", {31'd0, inst_valid}, 32'd0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkReset("rst_mid");
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        checkOutput("post_rst_ival", {31'd0, inst_valid}, 32'd0);
        checkOutput("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        checkOutput("post_rst_addr", bus.imem_addr, RV);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
